full_subtractor: RTL and testbench
==================================

// Module: full_subtractor
// PURPOSE
//   Ripple-borrow subtractor computing A - B - Bin, built from 1-bit full-subtractor slices.
//   Provides combinational Difference/Borrow outputs for immediate use.
//   Also provides a one-stage registered copy with valid tracking for pipelined datapaths.
//   Sits in the arithmetic library; the default WIDTH=1 is the classic 1-bit full subtractor.
// PARAMETERS
//   WIDTH  1  operand width in bits (>=1)
// PORTS
//   clk         in   1      clock; all registers update on rising edge
//   rst         in   1      asynchronous, active-high reset
//   A           in   WIDTH  minuend (unsigned)
//   B           in   WIDTH  subtrahend (unsigned)
//   Bin         in   1      borrow-in, weight 1
//   in_valid    in   1      qualifies A/B/Bin for the registered stage
//   Difference  out  WIDTH  combinational (A - B - Bin) mod 2^WIDTH
//   Borrow      out  1      combinational borrow-out: 1 iff A < B + Bin
//   diff_q      out  WIDTH  registered Difference
//   borrow_q    out  1      registered Borrow
//   out_valid   out  1      registered in_valid
//   ovf_q       out  1      registered signed overflow (see CONFIGURATION)
// BEHAVIOUR
//   Slice i (bin0 = Bin):
//   - d[i] = A[i]^B[i]^bin[i]
//   - bout[i] = (~A[i]&B[i]) | (~(A[i]^B[i])&bin[i])
//   - bin[i+1] = bout[i]; Borrow = bout[WIDTH-1]
//   Combinational path:
//   - zero latency; valid with no clock toggling and while rst is high
//   Registered path (latency 1):
//   - on rising clk with in_valid=1: diff_q<=Difference, borrow_q<=Borrow, ovf_q<=ovf
//   - in_valid=0: data registers hold their value
//   - out_valid<=in_valid every cycle
//   Reset:
//   - rst=1 asynchronously forces diff_q=0, borrow_q=0, out_valid=0, ovf_q=0
//   - regs stay at 0 while rst is held
//   - rst asserted mid-operation discards the in-flight result; out_valid drops at once
//   Boundary cases:
//   - A=B=0, Bin=1 gives Difference = all ones, Borrow=1 (wrap-around)
//   - A = 2^WIDTH-1, B=0, Bin=0 gives Difference=A, Borrow=0
//   - X/Z on inputs is not handled; the bench drives known values only
// CONFIGURATION
//   FULL_SUBTRACTOR_OVF_EN
//   - defined: ovf = (A[MSB]^B[MSB]) & (A[MSB]^Difference[MSB]), i.e. two's-complement
//     overflow of A - B - Bin; registered into ovf_q as above
//   - undefined: ovf_q is tied to 0 and no overflow logic is built
//   - Difference and Borrow are identical in both builds
// TESTING
//   1. WIDTH=1, no clock; apply all 8 {A,B,Bin} combinations 000..111, 10 ns apart.
//      Required {Difference,Borrow}: 00,11,11,01,10,00,00,11.
//   2. WIDTH=4: A=4'h3, B=4'h5, Bin=0 -> Difference=4'hE, Borrow=1;
//      with in_valid=1, next edge gives diff_q=4'hE, borrow_q=1, out_valid=1.
//   3. WIDTH=4: A=0, B=0, Bin=1 -> Difference=4'hF, Borrow=1;
//      A=4'hF, B=0, Bin=0 -> Difference=4'hF, Borrow=0.
//   4. Registered path loaded with 4'hE, then in_valid=0 for 3 cycles
//      -> diff_q holds 4'hE, out_valid=0.
//   5. Assert rst between clock edges -> diff_q, borrow_q, out_valid, ovf_q go to 0
//      immediately; combinational outputs stay correct.
//   6. OVF_EN, WIDTH=4: A=4'h8, B=4'h1, Bin=0 -> Difference=4'h7, ovf_q=1 after one edge;
//      same stimulus without the macro -> ovf_q=0.

Source files
------------

// File: rtl/full_subtractor.sv
// Ripple-borrow subtractor A - B - Bin built from 1-bit full-subtractor slices, plus a
// one-stage registered copy with valid tracking. Optional signed overflow: FULL_SUBTRACTOR_OVF_EN.
module full_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Difference,
  output logic             Borrow,
  output logic [WIDTH-1:0] diff_q,
  output logic             borrow_q,
  output logic             out_valid,
  output logic             ovf_q
);

  logic [WIDTH-1:0] diff_c;
  logic             borrow_c;

  // Each slice keeps its own borrow signals so the chain is a plain ripple, not a
  // self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic bin_i;
    logic bout;
    if (i == 0) begin : g_first
      assign bin_i = Bin;
    end else begin : g_rest
      assign bin_i = g_slice[i-1].bout;
    end
    assign diff_c[i] = A[i] ^ B[i] ^ bin_i;
    assign bout      = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & bin_i);
  end

  assign borrow_c   = g_slice[WIDTH-1].bout;
  assign Difference = diff_c;
  assign Borrow     = borrow_c;

  // Valid semantics: in_valid qualifies A/B/Bin on a rising edge; out_valid is in_valid
  // delayed one cycle, and the data registers only load on qualified cycles.
  logic [WIDTH-1:0] diff_d;
  logic             borrow_d;
  logic             out_valid_d;

  always_comb begin
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      diff_d   = diff_c;
      borrow_d = borrow_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      diff_q    <= diff_d;
      borrow_q  <= borrow_d;
      out_valid <= out_valid_d;
    end
  end

`ifdef FULL_SUBTRACTOR_OVF_EN
  logic ovf_c;
  logic ovf_d;

  // Operands of differing sign whose result takes the subtrahend's sign overflowed.
  assign ovf_c = (A[WIDTH-1] ^ B[WIDTH-1]) & (A[WIDTH-1] ^ diff_c[WIDTH-1]);

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = ovf_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`else
  assign ovf_q = 1'b0;
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Bench for full_subtractor: exhaustive 1-bit combinational table, then a 4-bit instance
// exercised through the registered path with an expected-result queue.
module tb_full_subtractor;

  // ---------------- clock / reset ----------------
  logic clk;
  logic clk_en;
  logic rst;

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic       a1, b1, bin1, in_valid1;
  logic       diff1, borrow1, diff_q1, borrow_q1, out_valid1, ovf_q1;

  logic [3:0] a4, b4;
  logic       bin4, in_valid4;
  logic [3:0] diff4, diff_q4;
  logic       borrow4, borrow_q4, out_valid4, ovf_q4;

  full_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Bin(bin1), .in_valid(in_valid1),
    .Difference(diff1), .Borrow(borrow1), .diff_q(diff_q1), .borrow_q(borrow_q1),
    .out_valid(out_valid1), .ovf_q(ovf_q1)
  );

  full_subtractor #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .Bin(bin4), .in_valid(in_valid4),
    .Difference(diff4), .Borrow(borrow4), .diff_q(diff_q4), .borrow_q(borrow_q4),
    .out_valid(out_valid4), .ovf_q(ovf_q4)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [5:0] exp_q[$];   // {ovf, borrow, diff[3:0]}
  logic [3:0] held_diff;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference, independent of the slice equations.
  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b,
                                       input logic bin);
    int r;
    int sr;
    logic [3:0] d;
    logic bo;
    logic ov;
    r  = int'(a) - int'(b) - int'(bin);
    d  = 4'(r);
    bo = (r < 0);
    sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
`ifdef FULL_SUBTRACTOR_OVF_EN
    ov = (sr < -8) || (sr > 7);
`else
    ov = 1'b0;
`endif
    return {ov, bo, d};
  endfunction

  // ---------------- driver tasks ----------------
  // Drive one 4-bit operand set at the falling edge, check the combinational outputs,
  // then check the registered outputs just after the next rising edge.
  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        input logic v);
    logic [5:0] e;
    logic [5:0] got;
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bin; in_valid4 = v;
    e = model4(a, b, bin);
    #1;
    chk("comb_diff4", 32'(diff4), 32'(e[3:0]));
    chk("comb_borrow4", 32'(borrow4), 32'(e[4]));
    if (v) exp_q.push_back(e);
    @(posedge clk);
    #1;
    chk("out_valid4", 32'(out_valid4), 32'(v));
    if (out_valid4) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_nonempty", 32'(0), 32'(1));
      end else begin
        got = exp_q.pop_front();
        chk("diff_q4", 32'(diff_q4), 32'(got[3:0]));
        chk("borrow_q4", 32'(borrow_q4), 32'(got[4]));
        chk("ovf_q4", 32'(ovf_q4), 32'(got[5]));
        held_diff = got[3:0];
      end
    end else begin
      chk("diff_q4_hold", 32'(diff_q4), 32'(held_diff));
    end
  endtask

  task automatic check_regs_zero(input string tag);
    chk({tag, "_diff_q4"}, 32'(diff_q4), 32'(0));
    chk({tag, "_borrow_q4"}, 32'(borrow_q4), 32'(0));
    chk({tag, "_out_valid4"}, 32'(out_valid4), 32'(0));
    chk({tag, "_ovf_q4"}, 32'(ovf_q4), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] tbl1 [8];

  initial begin
    tbl1[0] = 2'b00; tbl1[1] = 2'b11; tbl1[2] = 2'b11; tbl1[3] = 2'b01;
    tbl1[4] = 2'b10; tbl1[5] = 2'b00; tbl1[6] = 2'b00; tbl1[7] = 2'b11;
    clk_en = 1'b0;
    rst = 1'b1;
    a1 = 0; b1 = 0; bin1 = 0; in_valid1 = 0;
    a4 = 0; b4 = 0; bin4 = 0; in_valid4 = 0;
    held_diff = 4'h0;

    // 1-bit truth table with no clock and reset held: combinational path only.
    for (int i = 0; i < 8; i++) begin
      {a1, b1, bin1} = 3'(i);
      #10;
      chk($sformatf("w1_tbl_%0d", i), 32'({diff1, borrow1}), 32'(tbl1[i]));
    end
    chk("w1_rst_diff_q", 32'(diff_q1), 32'(0));
    chk("w1_rst_out_valid", 32'(out_valid1), 32'(0));
    chk("w1_rst_ovf_q", 32'(ovf_q1), 32'(0));
    check_regs_zero("rst_init");

    // Release reset and start the clock.
    rst = 1'b0;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    check_regs_zero("post_rst");

    // Directed: 3 - 5, wrap-around, all-ones minuend, signed overflow case.
    drive4(4'h3, 4'h5, 1'b0, 1'b1);
    drive4(4'h0, 4'h0, 1'b1, 1'b1);
    drive4(4'hF, 4'h0, 1'b0, 1'b1);
    drive4(4'h8, 4'h1, 1'b0, 1'b1);
    drive4(4'h7, 4'hF, 1'b1, 1'b1);

    // Load 4'hE then idle three cycles with changing operands: registers hold.
    drive4(4'h3, 4'h5, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'b0);
    end

    // Asynchronous reset between edges with a transaction in flight.
    @(negedge clk);
    a4 = 4'h8; b4 = 4'h1; bin4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk);
    #2;
    a4 = 4'h2; b4 = 4'h9; bin4 = 1'b1;
    rst = 1'b1;
    #1;
    check_regs_zero("async_rst");
    chk("rst_comb_diff4", 32'(diff4), 32'(model4(4'h2, 4'h9, 1'b1) & 6'h0F));
    chk("rst_comb_borrow4", 32'(borrow4), 32'(model4(4'h2, 4'h9, 1'b1) >> 4 & 6'h01));
    @(posedge clk);
    #1;
    check_regs_zero("rst_held");
    @(negedge clk);
    rst = 1'b0;
    in_valid4 = 1'b0;
    held_diff = 4'h0;

    // Random mix of valid and idle cycles.
    for (int i = 0; i < 24; i++) begin
      drive4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end
    drive4(4'h0, 4'h0, 1'b0, 1'b0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
